// File: rtl/seq_prop_checker_if.sv
// Signal bundle between the property checker and the logic that drives its operands.
interface seq_prop_checker_if #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned TS_W  = 32
) ();
   logic              en;
   logic              clr;
   logic              a;
   logic              b;
   logic              c;
   logic              d;
   logic              e;
   logic              f;
   logic              pass;
   logic [1:0]        fail;
   logic              vac;
   logic [CNT_W-1:0]  pass_cnt;
   logic [CNT_W-1:0]  fail_cnt;
   logic [CNT_W-1:0]  vac_cnt;
   logic              ff_valid;
   logic [TS_W-1:0]   ff_ts;
   logic              busy;

   modport master (
      output en, clr, a, b, c, d, e, f,
      input  pass, fail, vac, pass_cnt, fail_cnt, vac_cnt, ff_valid, ff_ts, busy
   );

   modport slave (
      input  en, clr, a, b, c, d, e, f,
      output pass, fail, vac, pass_cnt, fail_cnt, vac_cnt, ff_valid, ff_ts, busy
   );
endinterface

// File: rtl/seq_prop_checker.sv
// Hardware checker for: a ##1 b |-> (if (c) (1 |=> d) else e ##1 f).
// S1 holds attempts waiting on b/c/e, S2 holds attempts waiting on d or f.
module seq_prop_checker #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned TS_W  = 32
) (
   input logic                i_clk,
   input logic                i_rst,
   seq_prop_checker_if.slave  bus
);

   logic              r_s1;
   logic              r_exp_d;
   logic              r_exp_f;
   logic              r_pass;
   logic [1:0]        r_fail;
   logic              r_vac;
   logic [CNT_W-1:0]  r_pass_cnt;
   logic [CNT_W-1:0]  r_fail_cnt;
   logic [CNT_W-1:0]  r_vac_cnt;
   logic              r_ff_valid;
   logic [TS_W-1:0]   r_ff_ts;
   logic [TS_W-1:0]   r_ts;

   logic              w_vac;
   logic              w_set_d;
   logic              w_set_f;
   logic              w_pass;
   logic [1:0]        w_fail;
   logic [1:0]        w_fail_inc;
   logic [CNT_W-1:0]  w_pass_base;
   logic [CNT_W-1:0]  w_fail_base;
   logic [CNT_W-1:0]  w_vac_base;
   logic              w_ff_valid_d;
   logic [TS_W-1:0]   w_ff_ts_d;

   // Add 0..2 to a counter, clamping at all-ones.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, base} + (CNT_W+1)'(inc);
      if (sum[CNT_W]) begin
         return '1;
      end
      return sum[CNT_W-1:0];
   endfunction

   // Resolve the S1 and S2 attempts from this cycle's samples; clr zeroes the old totals first.
   always_comb begin
      w_vac        = r_s1 & ~bus.b;
      w_set_d      = r_s1 & bus.b & bus.c;
      w_set_f      = r_s1 & bus.b & ~bus.c & bus.e;
      w_fail       = 2'b00;
      w_fail[0]    = r_s1 & bus.b & ~bus.c & ~bus.e;
      w_fail[1]    = (r_exp_d & ~bus.d) | (r_exp_f & ~bus.f);
      w_pass       = (r_exp_d & bus.d) | (r_exp_f & bus.f);
      w_fail_inc   = {1'b0, w_fail[0]} + {1'b0, w_fail[1]};
      w_pass_base  = bus.clr ? '0 : r_pass_cnt;
      w_fail_base  = bus.clr ? '0 : r_fail_cnt;
      w_vac_base   = bus.clr ? '0 : r_vac_cnt;
      w_ff_valid_d = bus.clr ? 1'b0 : r_ff_valid;
      w_ff_ts_d    = bus.clr ? '0 : r_ff_ts;
      // Capture only the first failure since reset or clear.
      if ((w_fail != 2'b00) && !w_ff_valid_d) begin
         w_ff_valid_d = 1'b1;
         w_ff_ts_d    = r_ts;
      end
   end

   // Pipeline, outcome pulses, counters and timestamp; reset discards in-flight attempts.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1       <= 1'b0;
         r_exp_d    <= 1'b0;
         r_exp_f    <= 1'b0;
         r_pass     <= 1'b0;
         r_fail     <= 2'b00;
         r_vac      <= 1'b0;
         r_pass_cnt <= '0;
         r_fail_cnt <= '0;
         r_vac_cnt  <= '0;
         r_ff_valid <= 1'b0;
         r_ff_ts    <= '0;
         r_ts       <= '0;
      end else begin
         r_s1       <= bus.en & bus.a;
         r_exp_d    <= w_set_d;
         r_exp_f    <= w_set_f;
         r_pass     <= w_pass;
         r_fail     <= w_fail;
         r_vac      <= w_vac;
         r_pass_cnt <= sat_add(w_pass_base, {1'b0, w_pass});
         r_fail_cnt <= sat_add(w_fail_base, w_fail_inc);
         r_vac_cnt  <= sat_add(w_vac_base, {1'b0, w_vac});
         r_ff_valid <= w_ff_valid_d;
         r_ff_ts    <= w_ff_ts_d;
         r_ts       <= r_ts + TS_W'(1);
      end
   end

   assign bus.pass     = r_pass;
   assign bus.fail     = r_fail;
   assign bus.vac      = r_vac;
   assign bus.pass_cnt = r_pass_cnt;
   assign bus.fail_cnt = r_fail_cnt;
   assign bus.vac_cnt  = r_vac_cnt;
   assign bus.ff_valid = r_ff_valid;
   assign bus.ff_ts    = r_ff_ts;
   assign bus.busy     = r_s1 | r_exp_d | r_exp_f;

endmodule
